// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: slice opcodes,
// operand-invert bit positions and the controller state encoding.
package alu_serial_ctrl_pkg;

   // aluop[1:0] function select
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   // aluop bits that invert the a / b operand before the function
   localparam int unsigned INV_A_BIT = 3;
   localparam int unsigned INV_B_BIT = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Requester-side bus of the bit-serial ALU: start/done handshake, operands,
// opcode and published results. ALU_SERIAL_OVF_EN adds the ovf flag.
interface alu_serial_ctrl_if #(
   parameter int unsigned WIDTH = 8
);

   logic             start;
   logic [3:0]       aluop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             zero;

`ifdef ALU_SERIAL_OVF_EN
   logic             ovf;

   modport master (
      output start, aluop, a, b,
      input  busy, done, result, cout, zero, ovf
   );

   modport slave (
      input  start, aluop, a, b,
      output busy, done, result, cout, zero, ovf
   );
`else
   modport master (
      output start, aluop, a, b,
      input  busy, done, result, cout, zero
   );

   modport slave (
      input  start, aluop, a, b,
      output busy, done, result, cout, zero
   );
`endif

endinterface

// File: rtl/alu_1bit.sv
// One-bit ALU slice: optional operand inversion followed by AND / OR / full
// add. The reserved function yields 0 with no carry.
module alu_1bit
   import alu_serial_ctrl_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [3:0] aluop,
   output logic       res,
   output logic       cout
);

   logic ai;
   logic bi;

   assign ai = a ^ aluop[INV_A_BIT];
   assign bi = b ^ aluop[INV_B_BIT];

   // Function select; carry only meaningful for ADD
   always_comb begin
      res  = 1'b0;
      cout = 1'b0;
      unique case (aluop[1:0])
         OP_AND: res = ai & bi;
         OP_OR:  res = ai | bi;
         OP_ADD: begin
            res  = ai ^ bi ^ cin;
            cout = (ai & bi) | (ai & cin) | (bi & cin);
         end
         default: begin
            res  = 1'b0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer. Drives a single alu_1bit slice LSB first for
// WIDTH cycles, then publishes result/cout/zero for one done cycle.
// Define ALU_SERIAL_OVF_EN to add the signed-overflow output ovf.
module alu_serial_ctrl
   import alu_serial_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   alu_serial_ctrl_if.slave bus
);

   // Counter reaches WIDTH after the last bit, so it needs one spare code
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_next;
   logic [3:0]       op_q;
   logic             carry_q;
   logic [CntW-1:0]  cnt_q;
   logic             last_bit;
   logic             is_add;
   logic             bit_res;
   logic             bit_cout;

   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             zero_q;
`ifdef ALU_SERIAL_OVF_EN
   logic             ovf_q;
`endif

   alu_1bit u_slice (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .cin   (carry_q),
      .aluop (op_q),
      .res   (bit_res),
      .cout  (bit_cout)
   );

   assign is_add   = (op_q[1:0] == OP_ADD);
   assign last_bit = (cnt_q == CntW'(WIDTH - 1));
   // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
   assign acc_next = (acc_q >> 1) | {bit_res, {(WIDTH-1){1'b0}}};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only looked at in idle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (bus.start) state_d = StRun;
         StRun:  if (last_bit)  state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Operand shift registers, accumulator, carry FF and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  acc_q   <= '0;
                  op_q    <= bus.aluop;
                  cnt_q   <= '0;
                  // Seeding carry with the invert parity turns ADD into a-b / b-a
                  carry_q <= (bus.aluop[1:0] == OP_ADD) ?
                             (bus.aluop[INV_A_BIT] ^ bus.aluop[INV_B_BIT]) : 1'b0;
               end
            end
            StRun: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               acc_q   <= acc_next;
               carry_q <= is_add & bit_cout;
               cnt_q   <= cnt_q + CntW'(1);
            end
            default: ;
         endcase
      end
   end

   // Published outputs, loaded only on the edge that enters done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else if (state_q == StRun && last_bit) begin
         result_q <= acc_next;
         cout_q   <= is_add & bit_cout;
         zero_q   <= (acc_next == '0);
`ifdef ALU_SERIAL_OVF_EN
         // carry_q is the carry into the MSB during the last bit-cycle
         ovf_q    <= is_add & (carry_q ^ bit_cout);
`endif
      end
   end

   assign bus.busy   = (state_q == StRun);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.zero   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
   assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8): directed cases, random
// operations against an arithmetic reference model, start-while-busy,
// reset mid-run and held-start spacing. Honours ALU_SERIAL_OVF_EN.
module tb_alu_serial_ctrl;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_serial_ctrl_if #(.WIDTH(W)) bus ();

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       v;
   } vec_t;

   // Word-level reference: invert, then AND/OR/ADD with plain arithmetic
   function automatic void model(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic c, output logic z, output logic v);
      logic [7:0] x;
      logic [7:0] y;
      int         cin;
      int         us;
      int         ss;
      x   = op[3] ? ~a : a;
      y   = op[2] ? ~b : b;
      cin = (op[3] ^ op[2]) ? 1 : 0;
      c   = 1'b0;
      v   = 1'b0;
      case (op[1:0])
         2'b00: r = x & y;
         2'b01: r = x | y;
         2'b10: begin
            us = int'(x) + int'(y) + cin;
            ss = int'($signed(x)) + int'($signed(y)) + cin;
            r  = us[7:0];
            c  = (us > 255);
            v  = (ss > 127) || (ss < -128);
         end
         default: r = 8'h00;
      endcase
      z = (r == 8'h00);
   endfunction

   // Issue one operation; lat counts negedges from acceptance to done (-1 on timeout)
   task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cycles);
      @(negedge clk);
      bus.start = 1'b1;
      bus.aluop = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.aluop = 4'($urandom);
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      lat         = 0;
      busy_cycles = 0;
      while (bus.done !== 1'b1 && lat < 50) begin
         if (bus.busy === 1'b1) busy_cycles++;
         @(negedge clk);
         lat++;
      end
      if (lat >= 50) lat = -1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.aluop = 4'h0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.cout, bus.zero} !== 12'h000) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b result=%h cout=%b zero=%b, required all 0",
                  bus.busy, bus.done, bus.result, bus.cout, bus.zero);
      end
`ifdef ALU_SERIAL_OVF_EN
      checks++;
      if (bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: got %b required 0", bus.ovf);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      vec_t tbl[10];
      int   lat;
      int   bc;
      tbl[0] = '{4'b0010, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{4'b0110, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{4'b0110, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{4'b0011, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[9] = '{4'b1010, 8'h10, 8'h01, 8'hF1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bc);
         checks++;
         if (lat !== int'(W) || bc !== int'(W)) begin
            errors++;
            $display("FAIL dir%0d_timing: latency=%0d busy_cycles=%0d, required %0d/%0d",
                     i, lat, bc, W, W);
         end
         checks++;
         if (bus.result !== tbl[i].r || bus.cout !== tbl[i].c || bus.zero !== tbl[i].z) begin
            errors++;
            $display("FAIL dir%0d_result: got r=%h c=%b z=%b, required r=%h c=%b z=%b", i,
                     bus.result, bus.cout, bus.zero, tbl[i].r, tbl[i].c, tbl[i].z);
         end
`ifdef ALU_SERIAL_OVF_EN
         checks++;
         if (bus.ovf !== tbl[i].v) begin
            errors++;
            $display("FAIL dir%0d_ovf: got %b required %b", i, bus.ovf, tbl[i].v);
         end
`endif
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.result !== tbl[i].r) begin
            errors++;
            $display("FAIL dir%0d_after: done=%b result=%h, required done=0 result=%h",
                     i, bus.done, bus.result, tbl[i].r);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       v;
      int         lat;
      int         bc;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom);
         a  = 8'($urandom);
         b  = 8'($urandom);
         model(op, a, b, r, c, z, v);
         do_op(op, a, b, lat, bc);
         checks++;
         if (lat !== int'(W) || bus.result !== r || bus.cout !== c || bus.zero !== z) begin
            errors++;
            $display("FAIL rand%0d op=%b a=%h b=%h: got lat=%0d r=%h c=%b z=%b, required lat=%0d r=%h c=%b z=%b",
                     i, op, a, b, lat, bus.result, bus.cout, bus.zero, W, r, c, z);
         end
`ifdef ALU_SERIAL_OVF_EN
         checks++;
         if (bus.ovf !== v) begin
            errors++;
            $display("FAIL rand%0d_ovf: got %b required %b", i, bus.ovf, v);
         end
`endif
      end
   endtask

   task automatic test_start_during_run();
      logic [7:0] prev;
      int         lat;
      int         bc;
      int         dcnt;
      int         dk;
      int         moved;
      logic [7:0] dres;
      do_op(4'b0001, 8'hA0, 8'h05, lat, bc);   // leaves result=A5
      prev  = bus.result;
      dcnt  = 0;
      dk    = -1;
      moved = 0;
      dres  = 8'h00;
      @(negedge clk);
      bus.start = 1'b1;
      bus.aluop = 4'b0010;
      bus.a     = 8'h12;
      bus.b     = 8'h34;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 3) begin
            bus.start = 1'b1;
            bus.aluop = 4'b0001;
            bus.a     = 8'hFF;
            bus.b     = 8'h00;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            dcnt++;
            if (dk < 0) begin
               dk   = k;
               dres = bus.result;
            end
         end else if (dk < 0 && bus.result !== prev) begin
            moved++;
         end
      end
      checks++;
      if (dcnt !== 1 || dk !== int'(W)) begin
         errors++;
         $display("FAIL busy_start_done: got %0d done pulses first at %0d, required 1 at %0d",
                  dcnt, dk, W);
      end
      checks++;
      if (dres !== 8'h46) begin
         errors++;
         $display("FAIL busy_start_result: got %h required 46", dres);
      end
      checks++;
      if (moved !== 0) begin
         errors++;
         $display("FAIL busy_start_hold: result changed %0d cycles before done, required 0",
                  moved);
      end
   endtask

   task automatic test_reset_mid_run();
      int         lat;
      int         bc;
      int         stray;
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       v;
      do_op(4'b0010, 8'h5A, 8'h33, lat, bc);   // leaves result=8D
      @(negedge clk);
      bus.start = 1'b1;
      bus.aluop = 4'b0010;
      bus.a     = 8'hFF;
      bus.b     = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.cout, bus.zero} !== 12'h000) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b done=%b result=%h cout=%b zero=%b, required all 0",
                  bus.busy, bus.done, bus.result, bus.cout, bus.zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL midrun_quiet: %0d cycles with busy/done after reset, required 0", stray);
      end
      model(4'b0110, 8'h40, 8'h41, r, c, z, v);
      do_op(4'b0110, 8'h40, 8'h41, lat, bc);
      checks++;
      if (lat !== int'(W) || bus.result !== r || bus.cout !== c || bus.zero !== z) begin
         errors++;
         $display("FAIL midrun_recover: got lat=%0d r=%h c=%b z=%b, required lat=%0d r=%h c=%b z=%b",
                  lat, bus.result, bus.cout, bus.zero, W, r, c, z);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      int d1;
      int n;
      d0 = -1;
      d1 = -1;
      n  = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.aluop = 4'b0010;
      bus.a     = 8'h01;
      bus.b     = 8'h02;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (n == 0) d0 = k;
            if (n == 1) d1 = k;
            n++;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (d0 !== int'(W) || d1 - d0 !== int'(W) + 2) begin
         errors++;
         $display("FAIL held_start: done at %0d and %0d, required %0d and %0d",
                  d0, d1, W, 2 * W + 2);
      end
      checks++;
      if (bus.result !== 8'h03) begin
         errors++;
         $display("FAIL held_start_result: got %h required 03", bus.result);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL held_start_idle: busy=%b required 0", bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_during_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
